// File: rtl/nco_cfg_ctrl.sv
// NCO run-time configuration sequencer: merges base frequency, loop-filter correction and
// phase-offset requests into one {POFF, PINC} config beat per update. Optional macro: NCO_CFG_SAT_EN.
module nco_cfg_ctrl #(
   parameter int PW    = 32,
   parameter int ADJ_W = 24,
   parameter int GAP   = 8,
   parameter int CNT_W = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [PW-1:0]           freq_base,
   input  logic signed [ADJ_W-1:0] freq_adj,
   input  logic                    adj_vld,
   input  logic [PW-1:0]           phase_off,
   input  logic                    phase_vld,
   output logic [2*PW-1:0]         cfg_tdata,
   output logic                    cfg_tvalid,
   input  logic                    cfg_tready,
   output logic                    cfg_done,
   output logic [PW-1:0]           pinc_cur,
   output logic [CNT_W-1:0]        cfg_cnt,
   output logic                    busy
`ifdef NCO_CFG_SAT_EN
   ,
   output logic                    sat_flag
`endif
);

   localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

   typedef enum logic [1:0] {
      S_INIT,
      S_IDLE,
      S_SEND,
      S_HOLD
   } state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic                    load_init;
   logic                    load_upd;
   logic                    accept;
   logic                    pend_f;
   logic                    pend_p;
   logic signed [ADJ_W-1:0] adj_reg;
   logic [PW-1:0]           poff_reg;
   logic [PW-1:0]           poff_new;
   logic [PW-1:0]           pinc_new;
   logic [GAP_W-1:0]        gap_cnt;

`ifdef NCO_CFG_SAT_EN
   logic                    clamp;

   // Sum is formed two bits wider than PW so both overflow and underflow are visible.
   function automatic logic [PW:0] pinc_sat(input logic [PW-1:0]           base,
                                            input logic signed [ADJ_W-1:0] adj);
      logic signed [PW+1:0] sum;
      sum = $signed({2'b00, base}) + $signed({{(PW+2-ADJ_W){adj[ADJ_W-1]}}, adj});
      if (sum[PW+1]) begin
         return {1'b1, {PW{1'b0}}};
      end else if (sum[PW]) begin
         return {1'b1, {PW{1'b1}}};
      end else begin
         return {1'b0, sum[PW-1:0]};
      end
   endfunction

   assign {clamp, pinc_new} = pinc_sat(freq_base, adj_reg);
`else
   function automatic logic [PW-1:0] pinc_wrap(input logic [PW-1:0]           base,
                                               input logic signed [ADJ_W-1:0] adj);
      return base + {{(PW-ADJ_W){adj[ADJ_W-1]}}, adj};
   endfunction

   assign pinc_new = pinc_wrap(freq_base, adj_reg);
`endif

   // A beat without a phase request repeats the POFF still held in the config word.
   assign poff_new = pend_p ? poff_reg : cfg_tdata[2*PW-1:PW];
   assign accept   = cfg_tvalid & cfg_tready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_INIT;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      load_init = 1'b0;
      load_upd  = 1'b0;
      case (state)
         S_INIT: begin
            load_init = 1'b1;
            state_nxt = S_SEND;
         end
         S_IDLE: begin
            if (pend_f | pend_p) begin
               load_upd  = 1'b1;
               state_nxt = S_SEND;
            end
         end
         S_SEND: begin
            if (accept) begin
               state_nxt = S_HOLD;
            end
         end
         S_HOLD: begin
            if (gap_cnt == '0) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_INIT;
      endcase
   end

   // Request capture: latest strobe wins, and a strobe coinciding with consumption re-arms.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_f   <= 1'b0;
         pend_p   <= 1'b0;
         adj_reg  <= '0;
         poff_reg <= '0;
      end else begin
         if (adj_vld) begin
            pend_f  <= 1'b1;
            adj_reg <= freq_adj;
         end else if (load_upd) begin
            pend_f <= 1'b0;
         end
         if (phase_vld) begin
            pend_p   <= 1'b1;
            poff_reg <= phase_off;
         end else if (load_upd) begin
            pend_p <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cfg_tdata  <= '0;
         cfg_tvalid <= 1'b0;
         cfg_done   <= 1'b0;
         pinc_cur   <= '0;
         cfg_cnt    <= '0;
         busy       <= 1'b0;
         gap_cnt    <= '0;
`ifdef NCO_CFG_SAT_EN
         sat_flag   <= 1'b0;
`endif
      end else begin
         busy     <= (state_nxt != S_IDLE);
         cfg_done <= accept;
         if (load_init) begin
            cfg_tdata  <= {{PW{1'b0}}, freq_base};
            cfg_tvalid <= 1'b1;
         end
         if (load_upd) begin
            cfg_tdata  <= {poff_new, pinc_new};
            cfg_tvalid <= 1'b1;
`ifdef NCO_CFG_SAT_EN
            sat_flag   <= sat_flag | clamp;
`endif
         end
         if (accept) begin
            cfg_tvalid <= 1'b0;
            pinc_cur   <= cfg_tdata[PW-1:0];
            cfg_cnt    <= cfg_cnt + CNT_W'(1);
            gap_cnt    <= GAP_W'(GAP - 1);
         end else if ((state == S_HOLD) && (gap_cnt != '0)) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_nco_cfg_ctrl.sv
// Scoreboard bench for nco_cfg_ctrl: expected config beats are queued at stimulus time
// and compared as each beat is accepted.
module tb_nco_cfg_ctrl;

   localparam int PW    = 32;
   localparam int ADJ_W = 24;
   localparam int GAP   = 8;
   localparam int CNT_W = 16;

   logic                    clk;
   logic                    rst;
   logic [PW-1:0]           freq_base;
   logic signed [ADJ_W-1:0] freq_adj;
   logic                    adj_vld;
   logic [PW-1:0]           phase_off;
   logic                    phase_vld;
   logic [2*PW-1:0]         cfg_tdata;
   logic                    cfg_tvalid;
   logic                    cfg_tready;
   logic                    cfg_done;
   logic [PW-1:0]           pinc_cur;
   logic [CNT_W-1:0]        cfg_cnt;
   logic                    busy;
`ifdef NCO_CFG_SAT_EN
   logic                    sat_flag;
`endif

   nco_cfg_ctrl #(.PW(PW), .ADJ_W(ADJ_W), .GAP(GAP), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .freq_base  (freq_base),
      .freq_adj   (freq_adj),
      .adj_vld    (adj_vld),
      .phase_off  (phase_off),
      .phase_vld  (phase_vld),
      .cfg_tdata  (cfg_tdata),
      .cfg_tvalid (cfg_tvalid),
      .cfg_tready (cfg_tready),
      .cfg_done   (cfg_done),
      .pinc_cur   (pinc_cur),
      .cfg_cnt    (cfg_cnt),
      .busy       (busy)
`ifdef NCO_CFG_SAT_EN
      ,
      .sat_flag   (sat_flag)
`endif
   );

   int          n_chk = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          acc_prev = 0;
   int          acc_last = 0;
   logic [63:0] exp_q[$];
   logic [31:0] poff_last;
   logic [63:0] exp_stall;
   logic [15:0] cnt0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_pinc(input logic [31:0] b, input int a);
      longint s;
      s = longint'(b) + longint'(a);
`ifdef NCO_CFG_SAT_EN
      if (s > 64'sh0_FFFF_FFFF) return 32'hFFFF_FFFF;
      if (s < 0) return 32'h0;
`endif
      return s[31:0];
   endfunction

   always @(negedge clk) begin
      if (!rst && cfg_tvalid && cfg_tready) begin
         acc_prev = acc_last;
         acc_last = cyc;
         if (exp_q.size() == 0) chk("sb_nonempty", 64'(exp_q.size()), 64'd1);
         else chk("beat", cfg_tdata, exp_q.pop_front());
      end
   end

   task automatic strobe(input int a, input logic da, input logic [31:0] p, input logic dp);
      @(posedge clk); #1;
      freq_adj  = ADJ_W'(a);
      adj_vld   = da;
      phase_off = p;
      phase_vld = dp;
      @(posedge clk); #1;
      adj_vld   = 1'b0;
      phase_vld = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      bit seen = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (cfg_done) begin
            seen = 1;
            break;
         end
      end
      chk({tag, "_done"}, 64'(seen), 64'd1);
   endtask

   task automatic wait_idle(input string tag);
      bit seen = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (!busy) begin
            seen = 1;
            break;
         end
      end
      chk({tag, "_idle"}, 64'(seen), 64'd1);
   endtask

   task automatic wait_valid(input string tag);
      bit seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (cfg_tvalid) begin
            seen = 1;
            break;
         end
      end
      chk({tag, "_valid"}, 64'(seen), 64'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst        = 1'b1;
      cfg_tready = 1'b1;
      freq_base  = 32'h0CCC_CCCD;
      freq_adj   = '0;
      adj_vld    = 1'b0;
      phase_off  = '0;
      phase_vld  = 1'b0;
      poff_last  = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tvalid", 64'(cfg_tvalid), 64'd0);
      chk("rst_tdata", cfg_tdata, 64'd0);
      chk("rst_cnt", 64'(cfg_cnt), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(cfg_done), 64'd0);
      chk("rst_pinc", 64'(pinc_cur), 64'd0);
`ifdef NCO_CFG_SAT_EN
      chk("rst_sat", 64'(sat_flag), 64'd0);
`endif

      // Initial beat after reset release
      exp_q.push_back({32'h0, 32'h0CCC_CCCD});
      rst = 1'b0;
      wait_done("init");
      chk("init_cnt", 64'(cfg_cnt), 64'd1);
      chk("init_pinc", 64'(pinc_cur), 64'h0CCC_CCCD);
      @(negedge clk);
      chk("done_pulse", 64'(cfg_done), 64'd0);
      wait_idle("init");

      // Negative correction, two-cycle latency
      exp_q.push_back({poff_last, model_pinc(freq_base, -100)});
      strobe(-100, 1'b1, 32'h0, 1'b0);
      chk("lat1_tvalid", 64'(cfg_tvalid), 64'd0);
      @(posedge clk); #1;
      chk("lat2_tvalid", 64'(cfg_tvalid), 64'd1);
      wait_done("neg");
      chk("neg_pinc", 64'(pinc_cur), 64'h0CCC_CC69);
      wait_idle("neg");

      // Stall with three strobes: only the last one follows
      cfg_tready = 1'b0;
      exp_stall  = {poff_last, model_pinc(freq_base, 5)};
      exp_q.push_back(exp_stall);
      strobe(5, 1'b1, 32'h0, 1'b0);
      @(posedge clk); #1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         adj_vld  = (i == 3) || (i == 7) || (i == 11);
         freq_adj = (i == 3) ? 24'sd1 : (i == 7) ? 24'sd2 : 24'sd3;
         chk("stall_vld", 64'(cfg_tvalid), 64'd1);
         chk("stall_data", cfg_tdata, exp_stall);
      end
      exp_q.push_back({poff_last, model_pinc(freq_base, 3)});
      adj_vld    = 1'b0;
      cfg_tready = 1'b1;
      wait_done("stall1");
      wait_done("stall2");
      chk("stall_cnt", 64'(cfg_cnt), 64'd4);
      wait_idle("stall");
      repeat (12) @(negedge clk);
      chk("no_extra", 64'(cfg_cnt), 64'd4);

      // Simultaneous frequency and phase request merge into one beat
      cnt0      = cfg_cnt;
      poff_last = 32'h4000_0000;
      exp_q.push_back({poff_last, model_pinc(freq_base, -7)});
      strobe(-7, 1'b1, 32'h4000_0000, 1'b1);
      wait_done("merge");
      chk("merge_cnt", 64'(cfg_cnt), 64'(cnt0 + 16'd1));
      wait_idle("merge");
      repeat (12) @(negedge clk);
      chk("merge_single", 64'(cfg_cnt), 64'(cnt0 + 16'd1));

      // Back-to-back requests respect the minimum gap
      exp_q.push_back({poff_last, model_pinc(freq_base, 10)});
      exp_q.push_back({poff_last, model_pinc(freq_base, 11)});
      strobe(10, 1'b1, 32'h0, 1'b0);
      strobe(11, 1'b1, 32'h0, 1'b0);
      wait_done("gap1");
      wait_done("gap2");
      chk("gap_min", 64'((acc_last - acc_prev) >= GAP + 1), 64'd1);
      wait_idle("gap");

      // Base change alone causes no beat; then overflow case
      cnt0 = cfg_cnt;
      @(posedge clk); #1;
      freq_base = 32'hFFFF_FFF0;
      repeat (6) @(negedge clk);
      chk("base_only_vld", 64'(cfg_tvalid), 64'd0);
      chk("base_only_cnt", 64'(cfg_cnt), 64'(cnt0));
      exp_q.push_back({poff_last, model_pinc(freq_base, 32)});
      strobe(32, 1'b1, 32'h0, 1'b0);
      wait_done("ovf");
`ifdef NCO_CFG_SAT_EN
      chk("ovf_pinc", 64'(pinc_cur), 64'hFFFF_FFFF);
      chk("ovf_sat", 64'(sat_flag), 64'd1);
`else
      chk("ovf_pinc", 64'(pinc_cur), 64'h0000_0010);
`endif
      wait_idle("ovf");

      // Reset in the middle of SEND
      cfg_tready = 1'b0;
      strobe(1, 1'b1, 32'h0, 1'b0);
      wait_valid("mid");
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("arst_tvalid", 64'(cfg_tvalid), 64'd0);
      chk("arst_cnt", 64'(cfg_cnt), 64'd0);
`ifdef NCO_CFG_SAT_EN
      chk("arst_sat", 64'(sat_flag), 64'd0);
`endif
      freq_base = 32'h1234_5678;
      poff_last = 32'h0;
      exp_q.push_back({32'h0, 32'h1234_5678});
      @(posedge clk); #1;
      cfg_tready = 1'b1;
      rst        = 1'b0;
      wait_done("reinit");
      chk("reinit_cnt", 64'(cfg_cnt), 64'd1);
      chk("reinit_pinc", 64'(pinc_cur), 64'h1234_5678);
      wait_idle("reinit");

      chk("sb_empty", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
